// File: rtl/tt_ctrl_sel.sv
// Design-select sequencer: synchronises the async ctrl pads, tracks a target design
// address and moves the spine address with break-before-make on the spine enable.
module tt_ctrl_sel #(
  parameter int ADDR_W      = 10,
  parameter int ADDR_MAX    = 1023,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_sel_rst_n,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] spine_addr,
  output logic              spine_ena,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DROP,
    ST_LOAD,
    ST_SETTLE
  } state_t;

  localparam logic [3:0]        GUARD_LOAD = 4'(GUARD_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_MAX);

  // ---------------------------------------------------------------------------
  // Pad synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] ena_sync;
  logic                   rst_s;
  logic                   inc_s;
  logic                   ena_s;

  // NOTE: sequential state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The select-reset chain idles high so leaving reset never looks like a
      // forced return to address 0.
      rst_sync <= '1;
      inc_sync <= '0;
      ena_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
    end
  end

  assign rst_s = rst_sync[SYNC_STAGES-1];
  assign inc_s = inc_sync[SYNC_STAGES-1];
  assign ena_s = ena_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Increment edge detect and target address
  // ---------------------------------------------------------------------------
  logic              inc_d;
  logic              inc_edge;
  logic [ADDR_W-1:0] tgt;

  // One registered pulse per synchronised rise, however long the pad stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_d    <= 1'b0;
      inc_edge <= 1'b0;
    end else begin
      inc_d    <= inc_s;
      inc_edge <= inc_s & ~inc_d;
    end
  end

  // Select-reset beats a coincident increment; tgt keeps moving while busy so
  // no increment is lost during a guard sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt <= '0;
    end else if (!rst_s) begin
      tgt <= '0;
    end else if (inc_edge) begin
      tgt <= (tgt == ADDR_LAST) ? '0 : tgt + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Break-before-make FSM
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ena_d;
  logic              addr_mismatch;

  assign addr_mismatch = (tgt != spine_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACTIVE;
      cnt_q      <= '0;
      spine_addr <= '0;
      spine_ena  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spine_addr <= addr_d;
      spine_ena  <= ena_d;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE: if (addr_mismatch) state_d = ST_DROP;
      ST_DROP:   if (cnt_q == '0) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: begin
        // Increments that landed during the guard trigger another load.
        if (cnt_q == '0) state_d = addr_mismatch ? ST_LOAD : ST_ACTIVE;
      end
      default:   state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = spine_addr;
    ena_d  = 1'b0;
    unique case (state_q)
      ST_ACTIVE: begin
        if (addr_mismatch) begin
          cnt_d = GUARD_LOAD;
        end else begin
          ena_d = ena_s;
        end
      end
      ST_DROP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      end
      ST_LOAD: begin
        addr_d = tgt;
        cnt_d  = GUARD_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_ACTIVE);

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Self-checking bench for tt_ctrl_sel: expected spine values are queued with the
// cycle they are due and compared on the falling edge, plus a break-before-make monitor.
module tb_tt_ctrl_sel;

  localparam int ADDR_W = 10;
  localparam int AMAX   = 5;
  localparam int S      = 2;
  localparam int G      = 4;
  // Edge offsets from an inc pad rise, for a single isolated change.
  localparam int T_TGT  = S + 2;
  localparam int T_DROP = T_TGT + 1;
  localparam int T_LOAD = T_TGT + G + 2;
  localparam int T_ACT  = T_TGT + 2 * G + 2;
  localparam int T_ENA  = T_TGT + 2 * G + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  logic [ADDR_W-1:0] spine_addr;
  logic              spine_ena;
  logic              busy;

  tt_ctrl_sel #(
    .ADDR_W     (ADDR_W),
    .ADDR_MAX   (AMAX),
    .SYNC_STAGES(S),
    .GUARD_CYC  (G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_ena      (ctrl_ena),
    .spine_addr    (spine_addr),
    .spine_ena     (spine_ena),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected spine values keyed by the cycle they are due.
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              ena;
    logic              busy;
    string             name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input int at, input logic [ADDR_W-1:0] a, input logic e,
                      input logic b, input string name);
    exp_t x;
    x.cyc  = at;
    x.addr = a;
    x.ena  = e;
    x.busy = b;
    x.name = name;
    sb.push_back(x);
  endtask

  // Break-before-make monitor state.
  bit                mon_en       = 1'b0;
  logic [ADDR_W-1:0] prev_addr    = '0;
  logic              prev_ena     = 1'b0;
  int                low_run      = 0;
  int                since_change = 1000;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.name, "_addr"}, 32'(spine_addr), 32'(mon_e.addr));
      check({mon_e.name, "_ena"},  32'(spine_ena),  32'(mon_e.ena));
      check({mon_e.name, "_busy"}, 32'(busy),       32'(mon_e.busy));
    end
    if (mon_en) begin
      if (spine_addr !== prev_addr) begin
        check("bbm_ena_low_on_change", 32'(spine_ena), 32'd0);
        check("guard_before_change", 32'(low_run >= G), 32'd1);
        since_change = 0;
      end else if (since_change < 1000) begin
        since_change++;
      end
      if (spine_ena === 1'b1 && prev_ena === 1'b0)
        check("guard_after_change", 32'(since_change >= G), 32'd1);
      if (spine_ena === 1'b1) low_run = 0;
      else if (low_run < 1000) low_run++;
      prev_addr = spine_addr;
      prev_ena  = spine_ena;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      check("scoreboard_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    if (busy !== 1'b0) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    string             name;
    bit                sel_rst;
    int                n_inc;
    int                gap;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_ena;
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int i, input string name, input bit sr, input int n,
                         input int gap, input logic [ADDR_W-1:0] a, input logic e);
    vecs[i].name     = name;
    vecs[i].sel_rst  = sr;
    vecs[i].n_inc    = n;
    vecs[i].gap      = gap;
    vecs[i].exp_addr = a;
    vecs[i].exp_ena  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    set_vec(0, "single_2",    1'b0, 1, 30, 10'd2, 1'b1);
    set_vec(1, "single_3",    1'b0, 1, 30, 10'd3, 1'b1);
    set_vec(2, "sel_rst_0",   1'b1, 0,  0, 10'd0, 1'b1);
    set_vec(3, "burst_5",     1'b0, 5,  4, 10'd5, 1'b1);
    set_vec(4, "wrap_to_0",   1'b0, 1, 30, 10'd0, 1'b1);

    // Reset held with pads toggling: outputs pinned to reset values.
    rst_n          = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_addr", 32'(spine_addr), 32'd0);
      check("reset_ena",  32'(spine_ena),  32'd0);
      check("reset_busy", 32'(busy),       32'd0);
      @(posedge clk);
      #1;
      ctrl_sel_rst_n = 1'($urandom_range(0, 1));
      ctrl_sel_inc   = 1'($urandom_range(0, 1));
      ctrl_ena       = 1'($urandom_range(0, 1));
    end
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    mon_en = 1'b1;

    // Enable only: spine_ena follows after SYNC_STAGES+1 edges.
    base = cyc;
    ctrl_ena = 1'b1;
    push(base + S,     10'd0, 1'b0, 1'b0, "ena_early");
    push(base + S + 1, 10'd0, 1'b1, 1'b0, "ena_on");
    push(base + S + 4, 10'd0, 1'b1, 1'b0, "ena_hold");
    wait_sb(20);
    tick(2);

    // Single isolated increment: full guard timing edge by edge.
    base = cyc;
    ctrl_sel_inc = 1'b1;
    push(base + T_TGT,      10'd0, 1'b1, 1'b0, "single_pre");
    push(base + T_DROP,     10'd0, 1'b0, 1'b1, "single_drop");
    push(base + T_LOAD - 1, 10'd0, 1'b0, 1'b1, "single_preload");
    push(base + T_LOAD,     10'd1, 1'b0, 1'b1, "single_load");
    push(base + T_ACT - 1,  10'd1, 1'b0, 1'b1, "single_settle");
    push(base + T_ACT,      10'd1, 1'b0, 1'b0, "single_active");
    push(base + T_ENA,      10'd1, 1'b1, 1'b0, "single_ena");
    tick(2);
    ctrl_sel_inc = 1'b0;
    wait_sb(40);
    tick(10);

    // Table of convergent scenarios, compared once the FSM settles.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].sel_rst) begin
        ctrl_sel_rst_n = 1'b0;
        tick(6);
        ctrl_sel_rst_n = 1'b1;
      end
      for (int k = 0; k < vecs[v].n_inc; k++) begin
        ctrl_sel_inc = 1'b1;
        tick(2);
        ctrl_sel_inc = 1'b0;
        tick(vecs[v].gap - 2);
      end
      tick(2);
      wait_idle(200);
      tick(1);
      push(cyc, vecs[v].exp_addr, vecs[v].exp_ena, 1'b0, vecs[v].name);
      wait_sb(5);
      tick(3);
    end

    // Select-reset lands on the same tgt update edge as an increment: reset wins,
    // so tgt never leaves 0 and no guard sequence starts.
    base = cyc;
    ctrl_sel_inc = 1'b1;
    tick(1);
    ctrl_sel_rst_n = 1'b0;
    tick(1);
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    push(base + T_DROP,     10'd0, 1'b1, 1'b0, "rst_wins_drop");
    push(base + T_LOAD,     10'd0, 1'b1, 1'b0, "rst_wins_load");
    push(base + T_ENA + 1,  10'd0, 1'b1, 1'b0, "rst_wins_end");
    wait_sb(30);
    tick(4);

    // rst_n pulse during SETTLE: immediate return to reset values, no DROP after.
    base = cyc;
    ctrl_sel_inc = 1'b1;
    tick(2);
    ctrl_sel_inc = 1'b0;
    tick(T_LOAD + 1 - 2);
    check("settle_addr", 32'(spine_addr), 32'd1);
    check("settle_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(spine_addr), 32'd0);
    check("midrst_ena",  32'(spine_ena),  32'd0);
    check("midrst_busy", 32'(busy),       32'd0);
    tick(3);
    rst_n = 1'b1;
    base = cyc;
    push(base + S,     10'd0, 1'b0, 1'b0, "postrst_early");
    push(base + S + 1, 10'd0, 1'b1, 1'b0, "postrst_ena");
    push(base + S + 6, 10'd0, 1'b1, 1'b0, "postrst_idle");
    wait_sb(20);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
